mem_bus_router: RTL and testbench
=================================

# mem_bus_router

Parametrised byte-serial memory router between the CPU data bus and NUM_SLAVES memory-mapped slaves. It is the successor to the fixed-map memory top. It adds:
- a parameter-driven region decode table;
- little-endian multi-byte sequencing;
- unmapped-address and illegal-size error reporting;
- a per-byte response timeout.

It sits between the CPU load/store unit and the RAM, SDRAM, UART, PLIC and test slaves. Each slave keeps its existing one-byte request/DV handshake.

## Interface
- NUM_SLAVES, 4: number of slave channels, 1..16.
- ADDR_W, 32: bus and slave address width.
- REGION_BASE, 0: packed NUM_SLAVES*ADDR_W; slice s is the base of slave s.
- REGION_MASK, 0: packed NUM_SLAVES*ADDR_W; slice s is the compare mask of slave s.
- TIMEOUT, 1024: cycles to wait for one byte; 0 disables the timeout.

Ports (clock and reset first):
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_bus_address  in  ADDR_W  start byte address.
- i_bus_data  in  32  write data; byte k sits in [8k+7:8k].
- i_bus_DV  in  1  request strobe.
- i_bhw  in  3  byte count: 1, 2 or 4.
- i_write_notread  in  1  1 = write, 0 = read.
- o_bus_data  out  32  read data, zero-extended.
- o_bus_DV  out  1  completion flag, level.
- o_bus_err  out  1  error flag, valid while o_bus_DV is high.
- o_busy  out  1  high in every state other than IDLE.
- o_slv_request  out  NUM_SLAVES  one-hot, one-cycle request.
- o_slv_address  out  ADDR_W  byte address of the current request.
- o_slv_data  out  8  write byte of the current request.
- o_slv_write  out  1  direction of the current request.
- i_slv_data  in  8*NUM_SLAVES  read byte of slave s in [8s+7:8s].
- i_slv_DV  in  NUM_SLAVES  per-slave byte done.

## Operation
States: IDLE, ISSUE, WAIT.

- **Decode**: slave s matches when (addr & MASK_s) == BASE_s. The lowest matching index wins.
  - Decode is evaluated once, on the start address.
  - A transfer that crosses a region boundary stays on the selected slave.
- **IDLE**: i_bus_DV is accepted only in IDLE. On acceptance:
  - latch address, data, count, direction and select;
  - clear o_bus_DV, o_bus_err and o_bus_data, and the byte index;
  - if i_bhw is not 1, 2 or 4, or no region matches: stay in IDLE, and set o_bus_DV=1, o_bus_err=1 next cycle with no slave request;
  - otherwise go to ISSUE.
- **ISSUE**: drive the request, then go to WAIT and clear the timer.
  - o_slv_request[sel]=1.
  - o_slv_address = start + index, modulo 2^ADDR_W.
  - o_slv_data = byte[index].
- **WAIT**: i_slv_DV[sel] completes the byte.
  - On a read, store i_slv_data[sel] into o_bus_data byte[index].
  - If index == count-1: go to IDLE and set o_bus_DV=1, o_bus_err=0.
  - Otherwise: increment index and go to ISSUE.
  - DV pulses from non-selected slaves are ignored.
- **Timeout**: if the timer reaches TIMEOUT with no DV, abort the transfer.
  - Go to IDLE with o_bus_DV=1, o_bus_err=1.
  - Bytes already read are kept; remaining bytes read as 0.
  - Writes already issued are not undone.
- o_bus_DV stays high in IDLE until the next accepted request clears it on the accepting edge.
- i_bus_DV while busy is ignored; it is neither queued nor acknowledged.
- o_slv_address, o_slv_data and o_slv_write hold their values outside ISSUE.

## Timing
- Reset, with i_rst_n low at an edge: state IDLE, and every output 0.
  - Reset mid-transfer aborts it with no completion.
  - A slave DV arriving after reset is ignored.
- Cycle numbering: 0 is the cycle in which i_bus_DV is sampled in IDLE.
  - The first o_slv_request is in cycle 1.
  - If a slave answers L cycles after the request (L≥1), byte n completes at the end of cycle 1+n(1+L)+L.
  - o_bus_DV rises in the following cycle.
- L=1 examples:
  - 1 byte: o_bus_DV in cycle 3.
  - 4 bytes: o_bus_DV in cycle 9.
- Decode or size error: o_bus_DV=1, o_bus_err=1 in cycle 1.
- Timeout: WAIT lasts exactly TIMEOUT cycles, and the error completion appears in the next cycle.
- A DV arriving in the same cycle the timer expires counts as success.
- Earliest back-to-back request: the first cycle o_bus_DV is high.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles mid-transfer -> all outputs 0, state IDLE, and a late i_slv_DV causes no o_bus_DV.
- Read, 4 bytes, slave 1 (BASE 0x1000, MASK 0xF000), L=1, at 0x1FFE, bytes 0x11/0x22/0x33/0x44:
  - slave addresses 0x1FFE, 0x1FFF, 0x2000, 0x2001, all on slave 1;
  - o_bus_data=0x44332211, o_bus_DV in cycle 9, o_bus_err=0.
- Write, 2 bytes, data 0xABCD at 0x0010, slave 0 -> o_slv_data 0xCD then 0xAB at 0x0010 and 0x0011, o_slv_write=1, o_bus_DV=1.
- Unmapped address 0xF0000000, or i_bhw=3 -> no o_slv_request, o_bus_DV=o_bus_err=1 in cycle 1.
- Timeout, TIMEOUT=8, 2-byte read, slave answers byte 0 only with 0x5A -> o_bus_data=0x0000005A, o_bus_err=1, 8 cycles after the second request.
- Overlapping regions: slaves 0 and 2 both match, and a stray i_slv_DV[3] pulses during WAIT -> only slave 0 is requested, and the stray pulse is ignored.

Source files
------------

// File: rtl/mem_bus_router.sv
// mem_bus_router: byte-serial router from the CPU data bus to NUM_SLAVES memory-mapped slaves.
// The start address is decoded once against a base/mask table, with the lowest index winning.
// Multi-byte transfers then run little-endian, one byte per request/DV handshake.
// An optional per-byte timeout aborts a transfer that a slave never answers.

module mem_bus_router #(
  parameter int unsigned                    NUM_SLAVES  = 4,
  parameter int unsigned                    ADDR_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   REGION_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   REGION_MASK = '0,
  parameter int unsigned                    TIMEOUT     = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [ADDR_W-1:0]         i_bus_address,
  input  logic [31:0]               i_bus_data,
  input  logic                      i_bus_DV,
  input  logic [2:0]                i_bhw,
  input  logic                      i_write_notread,
  output logic [31:0]               o_bus_data,
  output logic                      o_bus_DV,
  output logic                      o_bus_err,
  output logic                      o_busy,
  output logic [NUM_SLAVES-1:0]     o_slv_request,
  output logic [ADDR_W-1:0]         o_slv_address,
  output logic [7:0]                o_slv_data,
  output logic                      o_slv_write,
  input  logic [8*NUM_SLAVES-1:0]   i_slv_data,
  input  logic [NUM_SLAVES-1:0]     i_slv_DV
);

  localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [31:0]             data_q;
  logic [1:0]              last_q;
  logic                    write_q;
  logic [SelW-1:0]         sel_q;
  logic [1:0]              idx_q;
  logic [31:0]             timer_q;
  logic [31:0]             bus_data_q;
  logic                    bus_dv_q;
  logic                    bus_err_q;
  logic [NUM_SLAVES-1:0]   req_q;
  logic [ADDR_W-1:0]       slv_addr_q;
  logic [7:0]              slv_data_q;
  logic                    slv_write_q;

  logic                    dec_hit;
  logic [SelW-1:0]         dec_sel;
  logic                    size_ok;
  logic [1:0]              idx_inc;

  assign size_ok = (i_bhw == 3'd1) || (i_bhw == 3'd2) || (i_bhw == 3'd4);
  assign idx_inc = idx_q + 2'd1;

  // Region decode of the start address; the first (lowest) matching slave wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (!dec_hit &&
          ((i_bus_address & REGION_MASK[s*ADDR_W +: ADDR_W]) == REGION_BASE[s*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_sel = SelW'(s);
      end
    end
  end

  // Transfer FSM; all bus and slave outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= '0;
      write_q     <= 1'b0;
      sel_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      bus_data_q  <= '0;
      bus_dv_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      req_q       <= '0;
      slv_addr_q  <= '0;
      slv_data_q  <= '0;
      slv_write_q <= 1'b0;
    end else begin
      // Request is a single-cycle pulse that coincides with ISSUE.
      req_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (i_bus_DV) begin
            addr_q     <= i_bus_address;
            data_q     <= i_bus_data;
            last_q     <= 2'(i_bhw - 3'd1);
            write_q    <= i_write_notread;
            sel_q      <= dec_sel;
            idx_q      <= '0;
            bus_data_q <= '0;
            if (!size_ok || !dec_hit) begin
              // Rejected without touching any slave; error completes next cycle.
              bus_dv_q  <= 1'b1;
              bus_err_q <= 1'b1;
            end else begin
              bus_dv_q       <= 1'b0;
              bus_err_q      <= 1'b0;
              state_q        <= StIssue;
              req_q[dec_sel] <= 1'b1;
              slv_addr_q     <= i_bus_address;
              slv_data_q     <= i_bus_data[7:0];
              slv_write_q    <= i_write_notread;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          timer_q <= '0;
        end
        StWait: begin
          // A DV in the expiry cycle still wins over the timeout.
          if (i_slv_DV[sel_q]) begin
            if (!write_q) begin
              bus_data_q[idx_q*8 +: 8] <= i_slv_data[sel_q*8 +: 8];
            end
            if (idx_q == last_q) begin
              state_q   <= StIdle;
              bus_dv_q  <= 1'b1;
              bus_err_q <= 1'b0;
            end else begin
              idx_q        <= idx_inc;
              state_q      <= StIssue;
              req_q[sel_q] <= 1'b1;
              slv_addr_q   <= addr_q + ADDR_W'(idx_inc);
              slv_data_q   <= data_q[idx_inc*8 +: 8];
            end
          end else if ((TIMEOUT != 0) && (timer_q == TIMEOUT - 1)) begin
            state_q   <= StIdle;
            bus_dv_q  <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy        = (state_q != StIdle);
  assign o_bus_data    = bus_data_q;
  assign o_bus_DV      = bus_dv_q;
  assign o_bus_err     = bus_err_q;
  assign o_slv_request = req_q;
  assign o_slv_address = slv_addr_q;
  assign o_slv_data    = slv_data_q;
  assign o_slv_write   = slv_write_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: expected slave requests and completions are queued
// when a transfer is launched and compared as the router produces them.

module tb_mem_bus_router;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;
  localparam logic [NS*AW-1:0] Base = {32'h0000_3000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] Mask = {32'hFFFF_F000, 32'hFFFF_FF00, 32'h0000_F000, 32'hFFFF_F000};

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     bus_address;
  logic [31:0]       bus_data_in;
  logic              bus_dv_in;
  logic [2:0]        bhw;
  logic              write_notread;
  logic [31:0]       bus_data;
  logic              bus_dv;
  logic              bus_err;
  logic              busy;
  logic [NS-1:0]     slv_request;
  logic [AW-1:0]     slv_address;
  logic [7:0]        slv_data;
  logic              slv_write;
  logic [8*NS-1:0]   slv_rdata;
  logic [NS-1:0]     slv_dv;

  mem_bus_router #(
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .REGION_BASE (Base),
    .REGION_MASK (Mask),
    .TIMEOUT     (TO)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_bus_address   (bus_address),
    .i_bus_data      (bus_data_in),
    .i_bus_DV        (bus_dv_in),
    .i_bhw           (bhw),
    .i_write_notread (write_notread),
    .o_bus_data      (bus_data),
    .o_bus_DV        (bus_dv),
    .o_bus_err       (bus_err),
    .o_busy          (busy),
    .o_slv_request   (slv_request),
    .o_slv_address   (slv_address),
    .o_slv_data      (slv_data),
    .o_slv_write     (slv_write),
    .i_slv_data      (slv_rdata),
    .i_slv_DV        (slv_dv)
  );

  typedef struct packed {
    logic [NS-1:0] req;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          wr;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } done_t;

  req_t        exp_req[$];
  done_t       exp_done[$];
  logic [7:0]  rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int lat      = 1;
  bit stray_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave model: answers each request after lat cycles with the next queued byte,
  // stays silent when the byte queue is empty, and can inject a stray DV on slave 3.
  initial begin
    int   pend;
    int   pend_sel;
    logic [7:0] pend_dat;
    req_t r;
    pend     = 0;
    pend_sel = 0;
    pend_dat = '0;
    slv_dv    = '0;
    slv_rdata = '0;
    forever begin
      @(negedge clk);
      slv_dv = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          slv_dv[pend_sel]           = 1'b1;
          slv_rdata[pend_sel*8 +: 8] = pend_dat;
        end else if (stray_en) begin
          slv_dv[3]         = 1'b1;
          slv_rdata[31:24]  = 8'hEE;
        end
      end
      if (slv_request != '0) begin
        if (exp_req.size() == 0) begin
          check_eq("unexp_req", 128'(slv_request), 128'd0);
        end else begin
          r = exp_req.pop_front();
          check_eq("req_sel",  128'(slv_request), 128'(r.req));
          check_eq("req_addr", 128'(slv_address), 128'(r.addr));
          check_eq("req_data", 128'(slv_data),    128'(r.data));
          check_eq("req_wr",   128'(slv_write),   128'(r.wr));
        end
        if (rsp_q.size() > 0) begin
          pend     = lat;
          pend_dat = rsp_q.pop_front();
          for (int s = 0; s < NS; s++) if (slv_request[s]) pend_sel = s;
        end
      end
    end
  end

  // Queue the per-byte requests a transfer should produce.
  task automatic expect_reqs(input logic [AW-1:0] a, input logic [31:0] d, input int n,
                             input logic w, input int sel);
    req_t r;
    for (int k = 0; k < n; k++) begin
      r.req  = NS'(1) << sel;
      r.addr = a + AW'(k);
      r.data = d[8*k +: 8];
      r.wr   = w;
      exp_req.push_back(r);
    end
  endtask

  task automatic expect_done(input logic [31:0] d, input logic e, input int c);
    done_t x;
    x.data = d;
    x.err  = e;
    x.cyc  = c;
    exp_done.push_back(x);
  endtask

  // Completion cycle when all n bytes are answered with latency l.
  function automatic int ok_cyc(input int n, input int l);
    return 2 + (n - 1) * (1 + l) + l;
  endfunction

  // Called at a negedge: that cycle is cycle 0; returns at the negedge of cycle 1.
  task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] b,
                      input logic w);
    bus_address   = a;
    bus_data_in   = d;
    bhw           = b;
    write_notread = w;
    bus_dv_in     = 1'b1;
    t0            = cyc;
    @(negedge clk);
    bus_dv_in     = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with o_bus_DV high (or after the budget).
  task automatic wait_done(input string tag);
    bit    seen;
    done_t e;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_dv) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_seen"}, 128'(seen), 128'd1);
    if (exp_done.size() == 0) begin
      check_eq({tag, "_noexp"}, 128'd1, 128'd0);
    end else begin
      e = exp_done.pop_front();
      if (seen) begin
        check_eq({tag, "_data"}, 128'(bus_data), 128'(e.data));
        check_eq({tag, "_err"},  128'(bus_err),  128'(e.err));
        check_eq({tag, "_cyc"},  128'(cyc - t0), 128'(e.cyc));
      end
    end
  endtask

  initial begin
    bit late_dv;
    rst_n         = 1'b0;
    bus_address   = '0;
    bus_data_in   = '0;
    bus_dv_in     = 1'b0;
    bhw           = 3'd1;
    write_notread = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {bus_data, bus_dv, bus_err, busy, slv_request, slv_address,
                            slv_data, slv_write}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4-byte read crossing a region boundary, stays on slave 1.
    lat = 1;
    expect_reqs(32'h0000_1FFE, 32'hDEAD_BEEF, 4, 1'b0, 1);
    rsp_q.push_back(8'h11); rsp_q.push_back(8'h22); rsp_q.push_back(8'h33); rsp_q.push_back(8'h44);
    expect_done(32'h4433_2211, 1'b0, ok_cyc(4, 1));
    send(32'h0000_1FFE, 32'hDEAD_BEEF, 3'd4, 1'b0);
    check_eq("rd4_busy", 128'(busy), 128'd1);
    wait_done("rd4");
    @(negedge clk);
    @(negedge clk);
    check_eq("rd4_dv_hold", 128'({bus_dv, busy}), 128'b10);

    // 2-byte write to slave 0.
    expect_reqs(32'h0000_0010, 32'h0000_ABCD, 2, 1'b1, 0);
    rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
    expect_done(32'h0, 1'b0, ok_cyc(2, 1));
    send(32'h0000_0010, 32'h0000_ABCD, 3'd2, 1'b1);
    wait_done("wr2");

    // Unmapped address, issued back-to-back in the first completion cycle.
    expect_done(32'h0, 1'b1, 1);
    send(32'hF000_0000, 32'h1234_5678, 3'd1, 1'b0);
    check_eq("unmap_busy", 128'(busy), 128'd0);
    wait_done("unmap");

    // Illegal size on a mapped address.
    expect_done(32'h0, 1'b1, 1);
    send(32'h0000_1000, 32'h0, 3'd3, 1'b0);
    wait_done("bhw3");

    // Timeout on the second byte; byte 0 is kept.
    expect_reqs(32'h0000_0020, 32'h0, 2, 1'b0, 0);
    rsp_q.push_back(8'h5A);
    expect_done(32'h0000_005A, 1'b1, 1 + (1 + 1) + TO + 1);
    send(32'h0000_0020, 32'h0, 3'd2, 1'b0);
    wait_done("tmo");

    // Overlapping regions 0 and 2; a stray slave-3 DV during WAIT is ignored.
    lat      = 2;
    stray_en = 1;
    expect_reqs(32'h0000_0040, 32'h0, 1, 1'b0, 0);
    rsp_q.push_back(8'h77);
    expect_done(32'h0000_0077, 1'b0, ok_cyc(1, 2));
    send(32'h0000_0040, 32'h0, 3'd1, 1'b0);
    wait_done("ovl");
    stray_en = 0;

    // Reset mid-transfer; the slave answers only after reset is released.
    lat = 6;
    expect_reqs(32'h0000_3000, 32'h0, 1, 1'b0, 3);
    rsp_q.push_back(8'h99);
    send(32'h0000_3000, 32'h0, 3'd1, 1'b0);
    check_eq("rst_busy", 128'(busy), 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_outs", {bus_data, bus_dv, bus_err, busy, slv_request, slv_address,
                             slv_data, slv_write}, 128'd0);
    rst_n   = 1'b1;
    late_dv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_dv || busy) late_dv = 1;
    end
    check_eq("late_dv", 128'(late_dv), 128'd0);

    check_eq("req_left", 128'(exp_req.size()), 128'd0);
    check_eq("done_left", 128'(exp_done.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
